// File: rtl/instrumentation_trip.sv
// instrumentation_trip: per-division trip unit for three sensor channels
// (0 temperature, 1 pressure, 2 saturation margin). Each accepted sample is
// compared against a programmable setpoint, debounced by a per-channel
// saturating counter and latched. The latched state is published as one
// 8-bit code per channel in a 24-bit trip word for the voting logic.
//
// Handshake: a sample transfers on a clk edge where in_valid & in_ready are
// both high; in_ready is high only in IDLE, in_valid is ignored otherwise and
// in_data is captured at the transfer edge, so it need not be held afterwards.
module instrumentation_trip #(
    parameter int             W        = 16,
    parameter int             DEBOUNCE = 2,
    parameter logic [W-1:0]   SP0_INIT = 16'hFFFF,
    parameter logic [W-1:0]   SP1_INIT = 16'hFFFF,
    parameter logic [W-1:0]   SP2_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3*W-1:0]   in_data,
    input  logic [2:0]       maint,
    input  logic             sp_we,
    input  logic [1:0]       sp_sel,
    input  logic [W-1:0]     sp_data,
    output logic             sp_err,
    input  logic             trip_reset,
    output logic [23:0]      trip_out,
    output logic             trip_any,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [3:0] DEB       = 4'(DEBOUNCE);
    localparam logic [7:0] CODE_NORM = 8'h00;
    localparam logic [7:0] CODE_TRIP = 8'h01;
    localparam logic [7:0] CODE_BYP  = 8'h02;

    state_t               state_q, state_d;
    logic [2:0][W-1:0]    samp_q, samp_d;
    logic [2:0][W-1:0]    sp_q, sp_d;
    logic [2:0]           exceed_q, exceed_d;
    logic [2:0][3:0]      cnt_q, cnt_d;
    logic [2:0]           latch_q, latch_d;
    logic [23:0]          trip_out_q, trip_out_d;
    logic                 sp_err_q, sp_err_d;

    logic                 load, eval, update;
    logic                 sel_bypassed;
    logic                 sp_ok;
    logic [2:0]           exceed_now;

    // Sequencing: IDLE accepts a sample, EVAL compares, UPDATE commits
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load     = 1'b0;
        eval     = 1'b0;
        update   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                eval    = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                update  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample capture on handshake; ch0 occupies the top slice of in_data
    always_comb begin
        samp_d = samp_q;
        if (load) begin
            samp_d[0] = in_data[3*W-1:2*W];
            samp_d[1] = in_data[2*W-1:W];
            samp_d[2] = in_data[W-1:0];
        end
    end

    // Exceed tests use the registered setpoints, so a write on the EVAL edge
    // only takes effect for later samples
    always_comb begin
        exceed_now[0] = samp_q[0] > sp_q[0];
        exceed_now[1] = samp_q[1] > sp_q[1];
        exceed_now[2] = samp_q[2] < sp_q[2];
        exceed_d      = eval ? exceed_now : exceed_q;
    end

    // Setpoint writes are only accepted for a channel that is in bypass
    always_comb begin
        sel_bypassed = 1'b0;
        case (sp_sel)
            2'd0:    sel_bypassed = maint[0];
            2'd1:    sel_bypassed = maint[1];
            2'd2:    sel_bypassed = maint[2];
            default: sel_bypassed = 1'b0;
        endcase
        sp_ok    = sp_we & sel_bypassed;
        sp_err_d = sp_we & ~sp_ok;
        sp_d     = sp_q;
        if (sp_ok) begin
            sp_d[sp_sel] = sp_data;
        end
    end

    // Debounce counters and latches; bypass overrides everything else
    always_comb begin
        cnt_d   = cnt_q;
        latch_d = latch_q;
        for (int c = 0; c < 3; c++) begin
            if (maint[c]) begin
                cnt_d[c]   = 4'd0;
                latch_d[c] = 1'b0;
            end else if (update) begin
                if (exceed_q[c]) begin
                    cnt_d[c] = (cnt_q[c] >= DEB) ? DEB : cnt_q[c] + 4'd1;
                end else begin
                    cnt_d[c] = 4'd0;
                end
                // A fresh trip wins over a concurrent operator reset
                latch_d[c] = (cnt_d[c] == DEB) |
                             (latch_q[c] & ~(trip_reset & (cnt_d[c] == 4'd0)));
            end else begin
                // Operator reset between samples only clears quiet channels
                latch_d[c] = latch_q[c] & ~(trip_reset & (cnt_q[c] == 4'd0));
            end
        end
    end

    // Output codes follow the next latch state and bypass one edge later
    always_comb begin
        trip_out_d = '0;
        for (int c = 0; c < 3; c++) begin
            if (maint[c]) begin
                trip_out_d[23-8*c -: 8] = CODE_BYP;
            end else if (latch_d[c]) begin
                trip_out_d[23-8*c -: 8] = CODE_TRIP;
            end else begin
                trip_out_d[23-8*c -: 8] = CODE_NORM;
            end
        end
    end

    // State register; reset aborts any in-flight sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            samp_q     <= '0;
            exceed_q   <= '0;
            cnt_q      <= '0;
            latch_q    <= '0;
            trip_out_q <= '0;
            sp_err_q   <= 1'b0;
            sp_q[0]    <= SP0_INIT;
            sp_q[1]    <= SP1_INIT;
            sp_q[2]    <= SP2_INIT;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            exceed_q   <= exceed_d;
            cnt_q      <= cnt_d;
            latch_q    <= latch_d;
            trip_out_q <= trip_out_d;
            sp_err_q   <= sp_err_d;
            sp_q       <= sp_d;
        end
    end

    assign trip_out    = trip_out_q;
    assign sp_err      = sp_err_q;
    assign trip_any    = |(latch_q & ~maint);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instrumentation_trip.sv
module tb_instrumentation_trip;

  localparam int W = 16;
  localparam int DEB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3*W-1:0] in_data = '0;
  logic [2:0]    maint = '0;
  logic          sp_we = 1'b0;
  logic [1:0]    sp_sel = '0;
  logic [W-1:0]  sp_data = '0;
  logic          sp_err;
  logic          trip_reset = 1'b0;
  logic [23:0]   trip_out;
  logic          trip_any;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  instrumentation_trip dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .maint(maint), .sp_we(sp_we), .sp_sel(sp_sel),
    .sp_data(sp_data), .sp_err(sp_err), .trip_reset(trip_reset),
    .trip_out(trip_out), .trip_any(trip_any), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: sample age since acceptance, counters and latches
  int           m_age = 0;          // 0 = free, 1/2 = edges since accept
  int           m_val[3];
  bit           m_exc[3];
  int           m_cnt[3];
  bit           m_lat[3];
  int           m_sp[3];
  bit           m_err = 0;
  logic [23:0]  m_out = '0;

  function automatic void model_reset();
    m_age = 0; m_err = 0; m_out = '0;
    m_sp[0] = 'hFFFF; m_sp[1] = 'hFFFF; m_sp[2] = 0;
    for (int c = 0; c < 3; c++) begin
      m_val[c] = 0; m_exc[c] = 0; m_cnt[c] = 0; m_lat[c] = 0;
    end
  endfunction

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      int  nsp[3];
      bit  quiet;
      nsp = m_sp;
      // setpoint write, accepted only for a bypassed channel
      m_err = 0;
      if (sp_we) begin
        if (sp_sel <= 2 && maint[sp_sel]) nsp[sp_sel] = int'(sp_data);
        else m_err = 1;
      end
      // commit step: two edges after acceptance
      for (int c = 0; c < 3; c++) begin
        if (maint[c]) begin
          m_cnt[c] = 0; m_lat[c] = 0;
        end else if (m_age == 2) begin
          m_cnt[c] = m_exc[c] ? ((m_cnt[c] + 1 > DEB) ? DEB : m_cnt[c] + 1) : 0;
          quiet = (m_cnt[c] == 0);
          m_lat[c] = (m_cnt[c] == DEB) || (m_lat[c] && !(trip_reset && quiet));
        end else if (trip_reset && m_cnt[c] == 0) begin
          m_lat[c] = 0;
        end
      end
      // comparison step: one edge after acceptance, old setpoints
      if (m_age == 1) begin
        m_exc[0] = m_val[0] > m_sp[0];
        m_exc[1] = m_val[1] > m_sp[1];
        m_exc[2] = m_val[2] < m_sp[2];
      end
      for (int c = 0; c < 3; c++)
        m_out[23-8*c -: 8] = maint[c] ? 8'h02 : (m_lat[c] ? 8'h01 : 8'h00);
      // acceptance
      if (m_age == 0 && in_valid) begin
        m_val[0] = int'(in_data[47:32]);
        m_val[1] = int'(in_data[31:16]);
        m_val[2] = int'(in_data[15:0]);
        m_age = 1;
      end else if (m_age == 1) m_age = 2;
      else m_age = 0;
      m_sp = nsp;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock; outputs compared with the model 1 time unit after the edge
  task automatic tick();
    bit any;
    @(posedge clk);
    #1;
    any = 0;
    for (int c = 0; c < 3; c++) any |= m_lat[c] && !maint[c];
    check("trip_out", 32'(trip_out), 32'(m_out));
    check("trip_any", 32'(trip_any), 32'(any));
    check("in_ready", 32'(in_ready), 32'(m_age == 0));
    check("sp_err", 32'(sp_err), 32'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sp_write(input logic [1:0] sel, input logic [W-1:0] val);
    sp_we = 1'b1; sp_sel = sel; sp_data = val;
    tick();
    sp_we = 1'b0;
  endtask

  // accepts one sample and returns after the commit edge (accept + 2)
  task automatic send(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2);
    in_valid = 1'b1; in_data = {c0, c1, c2};
    tick();
    in_valid = 1'b0; in_data = $urandom;
    ticks(2);
  endtask

  initial begin
    // reset values
    #12;
    check("rst_trip_out", 32'(trip_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_trip_any", 32'(trip_any), 32'h0);
    check("rst_sp_err", 32'(sp_err), 32'h0);
    @(negedge clk); rst = 1'b0;

    // program sp0 under bypass, then two exceeding ch0 samples
    maint = 3'b001;
    sp_write(2'd0, 16'h0100);
    maint = 3'b000;
    tick();
    in_valid = 1'b1; in_data = {16'h0200, 16'h0000, 16'hFFFF};
    tick(); in_valid = 1'b0;
    tick(); check("s1_e1", 32'(trip_out), 32'h0);
    tick(); check("s1_e2", 32'(trip_out), 32'h0);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); check("s2_e1", 32'(trip_out), 32'h0);
    tick(); check("s2_e2", 32'(trip_out), 32'h010000);
    check("s2_any", 32'(trip_any), 32'h1);

    // latch holds on a normal sample; operator reset then clears it
    send(16'h0050, 16'h0000, 16'hFFFF);
    check("hold", 32'(trip_out), 32'h010000);
    trip_reset = 1'b1; tick(); trip_reset = 1'b0;
    check("treset", 32'(trip_out), 32'h0);
    check("treset_any", 32'(trip_any), 32'h0);
    // re-latch; operator reset with counter non-zero keeps the latch
    send(16'h0200, 16'h0000, 16'hFFFF);
    send(16'h0200, 16'h0000, 16'hFFFF);
    trip_reset = 1'b1; tick(); trip_reset = 1'b0;
    check("treset_kept", 32'(trip_out), 32'h010000);

    // rejected setpoint writes
    sp_write(2'd1, 16'h0000);
    check("sp_err_nomaint", 32'(sp_err), 32'h1);
    tick(); check("sp_err_pulse", 32'(sp_err), 32'h0);
    maint = 3'b111;
    sp_write(2'd3, 16'h0000);
    check("sp_err_sel3", 32'(sp_err), 32'h1);
    maint = 3'b000;
    tick();
    send(16'h0000, 16'hFFFF, 16'hFFFF);
    send(16'h0000, 16'hFFFF, 16'hFFFF);
    check("sp1_unchanged", 32'(trip_out[15:8]), 32'h0);

    // latch ch2, then bypass it
    maint = 3'b100;
    sp_write(2'd2, 16'h0100);
    maint = 3'b000;
    tick();
    send(16'h0000, 16'h0000, 16'h0010);
    send(16'h0000, 16'h0000, 16'h0010);
    check("ch2_trip", 32'(trip_out), 32'h000001);
    maint = 3'b100; tick();
    check("ch2_byp", 32'(trip_out), 32'h000002);
    check("ch2_byp_any", 32'(trip_any), 32'h0);
    maint = 3'b000; tick();
    check("ch2_unbyp", 32'(trip_out), 32'h0);

    // reset during EVAL of an exceeding sample
    send(16'h0000, 16'h0000, 16'h0010);
    in_valid = 1'b1; in_data = {16'h0000, 16'h0000, 16'h0010};
    tick(); in_valid = 1'b0;
    rst = 1'b1; #1;
    check("arst_trip_out", 32'(trip_out), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    check("arst_trip_any", 32'(trip_any), 32'h0);
    @(negedge clk); rst = 1'b0;
    ticks(4);
    check("arst_after", 32'(trip_out), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = {16'($urandom_range(16'h00F0, 16'h0110)),
                    16'($urandom_range(16'h00F0, 16'h0110)),
                    16'($urandom_range(16'h00F0, 16'h0110))};
      maint      = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      sp_we      = ($urandom_range(0, 7) == 0);
      sp_sel     = 2'($urandom);
      sp_data    = 16'($urandom_range(16'h00F8, 16'h0108));
      trip_reset = ($urandom_range(0, 11) == 0);
      tick();
    end
    in_valid = 1'b0; sp_we = 1'b0; trip_reset = 1'b0; maint = '0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
